handshake_fifo_buffer: RTL and testbench



---
 rtl/handshake_fifo_buffer.sv | 79 +++++++
 tb/tb_handshake_fifo_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo_buffer.sv
// handshake_fifo_buffer
// Elastic ready/valid FIFO that sits between the combinational negate stage
// and its consumer. It absorbs consumer back-pressure. Upstream ready comes
// only from registered occupancy, so there is no combinational path from
// consumer ready back to producer ready.
//
// Ports
//   clock    in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   arg0     in   WIDTH  upstream data
//   arg1     in   1      upstream valid
//   arg2     in   1      downstream ready
//   ret0     out  1      upstream ready
//   ret1     out  WIDTH  downstream data (head of queue)
//   ret2     out  1      downstream valid
module handshake_fifo_buffer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] arg0,
   input  logic             arg1,
   input  logic             arg2,
   output logic             ret0,
   output logic [WIDTH-1:0] ret1,
   output logic             ret2
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // Pointer increment that wraps at DEPTH-1, so DEPTH need not be a power of 2.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // The reset_n term holds ready low during reset. count is already 0 then,
   // so without this term ready would read as high.
   assign ret0 = reset_n & (count != CNT_W'(DEPTH));
   assign ret2 = (count != '0);
   assign ret1 = mem[rd_ptr];

   assign push = arg1 & ret0;
   assign pop  = ret2 & arg2;

   // Storage, pointers and occupancy.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= arg0;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// tb_handshake_fifo_buffer
// Self-checking bench for handshake_fifo_buffer. A queue model predicts
// ready, valid and head data on every cycle. Fixed vector tables cover the
// single-word, fill, drain and wrap cases. Hand-written sequences cover reset,
// simultaneous push/pop and random back-pressure with a negate stage upstream.
module tb_handshake_fifo_buffer;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 4;

   logic             clock = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] arg0;
   logic             arg1;
   logic             arg2;
   logic             ret0;
   logic [WIDTH-1:0] ret1;
   logic             ret2;

   handshake_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .arg0   (arg0),
      .arg1   (arg1),
      .arg2   (arg2),
      .ret0   (ret0),
      .ret1   (ret1),
      .ret2   (ret2)
   );

   always #5 clock = ~clock;

   int n_vec  = 0;
   int n_miss = 0;

   logic [WIDTH-1:0] sb [$];
   logic             hold;
   logic [WIDTH-1:0] held;

   typedef struct {
      logic             a1;
      logic [WIDTH-1:0] a0;
      logic             a2;
      logic             e0;
      logic             e2;
      logic             ck;
      logic [WIDTH-1:0] e1;
   } vec_t;

   vec_t tbl [17];

   function automatic void chk(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Check the outputs against the model, clock once, then advance the model.
   task automatic step();
      logic do_push;
      logic do_pop;
      chk("ret0", WIDTH'(ret0), WIDTH'(sb.size() != DEPTH));
      chk("ret2", WIDTH'(ret2), WIDTH'(sb.size() != 0));
      if (sb.size() != 0) chk("ret1", ret1, sb[0]);
      if (hold) chk("ret1_stable", ret1, held);
      hold    = (sb.size() != 0) && !arg2;
      held    = (sb.size() != 0) ? sb[0] : '0;
      do_push = arg1 && (sb.size() != DEPTH);
      do_pop  = arg2 && (sb.size() != 0);
      @(posedge clock);
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(arg0);
      #1;
   endtask

   initial begin
      int acc;
      int cyc;
      logic [WIDTH-1:0] x;

      // Single word, fill, full-reject, drain, wrap.
      tbl[0]  = '{1'b1, 32'hFFFFFE5C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFE5C};
      tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, 32'd1,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 32'd2,        1'b0, 1'b1, 1'b1, 1'b1, 32'd1};
      tbl[5]  = '{1'b1, 32'd3,        1'b0, 1'b1, 1'b1, 1'b1, 32'd1};
      tbl[6]  = '{1'b1, 32'd4,        1'b0, 1'b1, 1'b1, 1'b1, 32'd1};
      tbl[7]  = '{1'b1, 32'd5,        1'b0, 1'b0, 1'b1, 1'b1, 32'd1};
      tbl[8]  = '{1'b1, 32'd5,        1'b0, 1'b0, 1'b1, 1'b1, 32'd1};
      tbl[9]  = '{1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 1'b1, 32'd1};
      tbl[10] = '{1'b0, 32'd0,        1'b1, 1'b1, 1'b1, 1'b1, 32'd2};
      tbl[11] = '{1'b0, 32'd0,        1'b1, 1'b1, 1'b1, 1'b1, 32'd3};
      tbl[12] = '{1'b0, 32'd0,        1'b1, 1'b1, 1'b1, 1'b1, 32'd4};
      tbl[13] = '{1'b1, 32'd69,       1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
      tbl[14] = '{1'b1, 32'hFFFFFFBB, 1'b1, 1'b1, 1'b1, 1'b1, 32'd69};
      tbl[15] = '{1'b0, 32'd0,        1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFBB};
      tbl[16] = '{1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

      hold    = 1'b0;
      held    = '0;
      reset_n = 1'b0;
      arg0    = '0;
      arg1    = 1'b0;
      arg2    = 1'b0;
      #1;
      chk("por_ret0", WIDTH'(ret0), '0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      #1;

      // Reset mid-stream with three words held.
      for (int i = 0; i < 3; i++) begin
         arg1 = 1'b1;
         arg0 = WIDTH'(100 + i);
         step();
      end
      arg1    = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("rst_ret0", WIDTH'(ret0), '0);
      chk("rst_ret2", WIDTH'(ret2), '0);
      chk("rst_ret1", ret1, '0);
      sb.delete();
      hold = 1'b0;
      @(posedge clock);
      #1;
      chk("rst_hold_ret0", WIDTH'(ret0), '0);
      reset_n = 1'b1;
      #1;
      chk("rel_ret0", WIDTH'(ret0), WIDTH'(1));
      chk("rel_ret2", WIDTH'(ret2), '0);

      // Table vectors.
      for (int i = 0; i < 17; i++) begin
         arg1 = tbl[i].a1;
         arg0 = tbl[i].a0;
         arg2 = tbl[i].a2;
         chk("tbl_ret0", WIDTH'(ret0), WIDTH'(tbl[i].e0));
         chk("tbl_ret2", WIDTH'(ret2), WIDTH'(tbl[i].e2));
         if (tbl[i].ck) chk("tbl_ret1", ret1, tbl[i].e1);
         step();
      end

      // Simultaneous push and pop at count 2.
      arg2 = 1'b0;
      arg1 = 1'b1;
      arg0 = 32'd7;
      step();
      arg0 = 32'd8;
      step();
      for (int i = 0; i < 10; i++) begin
         arg1 = 1'b1;
         arg2 = 1'b1;
         arg0 = WIDTH'(10 + i);
         chk("sim_ret0", WIDTH'(ret0), WIDTH'(1));
         step();
      end
      chk("sim_count", WIDTH'(sb.size()), WIDTH'(2));
      arg1 = 1'b0;
      arg2 = 1'b1;
      for (int i = 0; i < 3; i++) step();

      // Random back-pressure with a negate stage feeding arg0.
      acc = 0;
      cyc = 0;
      while (acc < 1000 && cyc < 20000) begin
         x    = $urandom;
         arg0 = -x;
         arg1 = 1'($urandom_range(0, 1));
         arg2 = 1'($urandom_range(0, 1));
         if (arg1 && sb.size() != DEPTH) acc++;
         step();
         cyc++;
      end
      chk("rand_accepted", WIDTH'(acc), WIDTH'(1000));
      arg1 = 1'b0;
      arg2 = 1'b1;
      while (sb.size() != 0 && cyc < 25000) begin
         step();
         cyc++;
      end
      chk("rand_drained", WIDTH'(sb.size()), '0);
      chk("final_ret2", WIDTH'(ret2), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
